// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, priority rule codes, reset PC.
// Imported by pipe_hazard_ctrl; the optional statistics are selected with PRED_STATS_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IMISS,
        IMISS_REDIR
    } state_t;

    typedef enum logic [2:0] {
        RULE_NONE,
        RULE_DMISS,
        RULE_MISPRED,
        RULE_LOAD_USE,
        RULE_JUMP,
        RULE_IMISS
    } rule_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Oldest blocking condition wins; lower-priority requests are ignored this cycle.
    function automatic rule_t pick_rule(input logic dmiss, input logic mispred,
                                        input logic load_use, input logic jump,
                                        input logic imiss);
        if (dmiss)         return RULE_DMISS;
        else if (mispred)  return RULE_MISPRED;
        else if (load_use) return RULE_LOAD_USE;
        else if (jump)     return RULE_JUMP;
        else if (imiss)    return RULE_IMISS;
        else               return RULE_NONE;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / pipeline control bundle between the pipeline (master) and the sequencer (slave).
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);

    logic             icache_miss_f;
    logic             dcache_miss_m;
    logic             load_use_d;
    logic             jump_d;
    logic [31:0]      jump_target_d;
    logic             mispredict_e;
    logic [31:0]      redirect_target_e;
    logic             branch_e;

    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_m, flush_w;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             redirect_pending;
    logic [CNT_W-1:0] cycle_cnt, branch_cnt, mispred_cnt;

    modport master (
        output icache_miss_f, dcache_miss_m, load_use_d, jump_d, jump_target_d,
               mispredict_e, redirect_target_e, branch_e,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
               pc_redirect, pc_target, redirect_pending, cycle_cnt, branch_cnt, mispred_cnt
    );

    modport slave (
        input  icache_miss_f, dcache_miss_m, load_use_d, jump_d, jump_target_d,
               mispredict_e, redirect_target_e, branch_e,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
               pc_redirect, pc_target, redirect_pending, cycle_cnt, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the optional predictor statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with redirect hold-and-replay across I-cache misses.
// Define PRED_STATS_EN to build the cycle/branch/mispredict statistics counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_t      state;
    logic [31:0] pend_target;
    logic        pending;
    rule_t       rule;
    logic        replay;
    logic        redir_req;
    logic        latch_redir;
    logic [31:0] redir_target;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rule             = pick_rule(bus.dcache_miss_m, bus.mispredict_e, bus.load_use_d,
                                     bus.jump_d, bus.icache_miss_f);
        replay           = (state == IMISS_REDIR) && !bus.icache_miss_f && !bus.dcache_miss_m;
        redir_req        = 1'b0;
        redir_target     = RESET_PC;
        bus.stall_f      = 1'b0;
        bus.stall_d      = 1'b0;
        bus.stall_e      = 1'b0;
        bus.stall_m      = 1'b0;
        bus.flush_d      = 1'b0;
        bus.flush_e      = 1'b0;
        bus.flush_m      = 1'b0;
        bus.flush_w      = 1'b0;
        bus.pc_redirect  = 1'b0;
        bus.pc_target    = '0;

        if (replay) begin
            // D holds a stale wrong-path fetch, so D-stage requests are moot; only EX can override.
            bus.pc_redirect = 1'b1;
            bus.flush_d     = 1'b1;
            bus.flush_e     = bus.mispredict_e;
            bus.pc_target   = bus.mispredict_e ? bus.redirect_target_e : pend_target;
        end else begin
            unique case (rule)
                RULE_DMISS: begin
                    bus.stall_f = 1'b1;
                    bus.stall_d = 1'b1;
                    bus.stall_e = 1'b1;
                    bus.stall_m = 1'b1;
                    bus.flush_w = 1'b1;
                end
                RULE_MISPRED: begin
                    bus.flush_d  = 1'b1;
                    bus.flush_e  = 1'b1;
                    redir_req    = 1'b1;
                    redir_target = bus.redirect_target_e;
                end
                RULE_LOAD_USE: begin
                    bus.stall_f = 1'b1;
                    bus.stall_d = 1'b1;
                    bus.flush_e = 1'b1;
                end
                RULE_JUMP: begin
                    bus.flush_d  = 1'b1;
                    redir_req    = 1'b1;
                    redir_target = bus.jump_target_d;
                end
                RULE_IMISS: begin
                    bus.stall_f = 1'b1;
                    bus.flush_d = 1'b1;
                end
                default: ;
            endcase

            if (redir_req) begin
                if (bus.icache_miss_f) begin
                    bus.stall_f = 1'b1;
                end else begin
                    bus.pc_redirect = 1'b1;
                    bus.pc_target   = redir_target;
                end
            end
        end
    end

    assign latch_redir = redir_req && bus.icache_miss_f;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend_target <= RESET_PC;
            pending     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, IMISS: begin
                    if (latch_redir) begin
                        state       <= IMISS_REDIR;
                        pend_target <= redir_target;
                        pending     <= 1'b1;
                    end else begin
                        state <= bus.icache_miss_f ? IMISS : IDLE;
                    end
                end
                IMISS_REDIR: begin
                    if (replay) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                    end else if (latch_redir) begin
                        pend_target <= redir_target;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect_pending = pending;

    logic [CNT_W-1:0] cycle_cnt, branch_cnt, mispred_cnt;

`ifdef PRED_STATS_EN
    // A branch held under a D-miss re-resolves later, so it counts only when EX advances.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst(rst), .inc(1'b1), .count(cycle_cnt)
    );
    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst(rst), .inc(bus.branch_e && !bus.stall_e), .count(branch_cnt)
    );
    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk(clk), .rst(rst), .inc(bus.mispredict_e && !bus.stall_e), .count(mispred_cnt)
    );
`else
    logic stats_unused;
    assign stats_unused = bus.branch_e;
    assign cycle_cnt    = '0;
    assign branch_cnt   = '0;
    assign mispred_cnt  = '0;
`endif

    assign bus.cycle_cnt   = cycle_cnt;
    assign bus.branch_cnt  = branch_cnt;
    assign bus.mispred_cnt = mispred_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It arbitrates between data-cache miss, EX-stage branch misprediction, load-use hazard, ID-stage jump and instruction-cache miss, and drives per-stage stall and flush, which also gate the branch predictor's update and pipeline-tracking registers. It holds any redirect that arrives while fetch is blocked by an I-cache miss, then replays it when the miss clears. Optional saturating counters measure predictor accuracy.

## Interface
- CNT_W, 32: width of each statistics counter.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- icache_miss_f  in  1  fetch blocked by I-cache miss
- dcache_miss_m  in  1  MEM blocked by D-cache miss
- load_use_d  in  1  ID instruction depends on the load in EX
- jump_d  in  1  unconditional jump resolved in ID
- jump_target_d  in  32  jump target
- mispredict_e  in  1  EX branch mispredicted (predicted-taken-not-taken, or taken-not-predicted)
- redirect_target_e  in  32  correct next PC from EX
- branch_e  in  1  a conditional branch is resolving in EX
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into the stage register
- pc_redirect  out  1  PC mux selects pc_target this cycle
- pc_target  out  32  redirect PC
- redirect_pending  out  1  a held redirect is waiting for the I-miss to end
- cycle_cnt, branch_cnt, mispred_cnt  out  CNT_W each  statistics counters

## Operation
- State: IDLE, IMISS, IMISS_REDIR. pend_target[31:0] is registered.
- Evaluate in strict priority order. Outputs not named in a rule are 0.
  1. dcache_miss_m: set stall_f/d/e/m and flush_w. No redirect. mispredict_e, jump_d and load_use_d are ignored; the EX instruction is held and re-resolves later.
  2. mispredict_e: flush_d and flush_e. Redirect to redirect_target_e.
  3. load_use_d: stall_f and stall_d, flush_e.
  4. jump_d: flush_d. Redirect to jump_target_d.
  5. icache_miss_f: stall_f, flush_d.
- Redirect acceptance:
  - With icache_miss_f=0, an accepted redirect drives pc_redirect=1 and pc_target combinationally.
  - With icache_miss_f=1, pc_redirect=0 and stall_f=1. The target is latched into pend_target and the state moves to IMISS_REDIR.
  - In IMISS_REDIR, a newer accepted redirect overwrites pend_target. The newest accepted redirect is always from the oldest live instruction.
- State transitions:
  - IDLE→IMISS: icache_miss_f=1 and no redirect accepted.
  - IMISS→IMISS_REDIR: a redirect is accepted.
  - IMISS→IDLE: icache_miss_f falls.
  - IMISS_REDIR→IDLE: the first cycle with icache_miss_f=0 and dcache_miss_m=0. In that cycle:
    - pc_redirect=1, pc_target=pend_target;
    - flush_d=1 kills the stale returned fetch;
    - a simultaneous EX mispredict takes precedence as the target.
- redirect_pending is 1 exactly in IMISS_REDIR.
- Counters:
  - cycle_cnt increments every cycle.
  - branch_cnt increments on branch_e && !stall_e.
  - mispred_cnt increments on mispredict_e && !stall_e.
  - All counters saturate at 2^CNT_W-1.

## Timing
- All stall, flush and redirect outputs are combinational from inputs and state. No added latency: a redirect takes effect at the next clk edge.
- State, pend_target and counters update on posedge clk.
- Reset: state=IDLE, pend_target=0, all counters 0.
- Reset values of outputs follow the all-inputs-0 state: all stalls and flushes 0, pc_redirect=0, pc_target=0, redirect_pending=0.
- Reset mid-miss discards any pending redirect.
- flush_x never asserts together with stall_x for the same stage. Rule 3 stalls D and flushes E only.
- A mispredict held under dcache_miss_m is not counted until the cycle stall_e drops.

## Configuration
- PRED_STATS_EN defined: the three counters and their logic are built.
- PRED_STATS_EN undefined: cycle_cnt, branch_cnt and mispred_cnt are constant 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - the state enum (IDLE, IMISS, IMISS_REDIR);
  - the priority rule codes;
  - the RESET_PC constant (0) used for pend_target.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated three times under PRED_STATS_EN.

## Test plan
- mispredict_e=1, redirect_target_e=0x0000_0040, no misses → same cycle pc_redirect=1, pc_target=0x40, flush_d=flush_e=1; mispred_cnt 0→1 after the edge.
- dcache_miss_m and mispredict_e both high for 3 cycles, then the miss drops → stall_f/d/e/m=1, flush_w=1 and no redirect for 3 cycles; redirect to the target on cycle 4; mispred_cnt increments once.
- icache_miss_f=1 for 4 cycles with jump_d (target 0x100) in cycle 1 → redirect_pending=1 cycles 2–4; in the cycle the miss falls, pc_redirect=1, pc_target=0x100, flush_d=1, then state IDLE.
- In IMISS_REDIR (pend 0x100), mispredict_e with target 0x200 → pend_target=0x200; replay uses 0x200.
- load_use_d alone → stall_f=stall_d=1, flush_e=1, pc_redirect=0. load_use_d with jump_d → load-use wins, no redirect.
- rst asserted while in IMISS_REDIR → redirect_pending=0 immediately. With PRED_STATS_EN, counters read 0. The next miss-end produces no redirect.
